// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, default
// frame-start byte and small helpers for assembling instruction words.
package program_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN_HI = 4'd1,
    S_LEN_LO = 4'd2,
    S_B0     = 4'd3,
    S_B1     = 4'd4,
    S_B2     = 4'd5,
    S_CSUM   = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_e;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  // Instruction word: low two bits of B0 on top, then B1, then B2.
  function automatic logic [17:0] make_word(input logic [1:0] b0_lo,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2);
    return {b0_lo, b1, b2};
  endfunction

  // Upper six bits of B0 (bits 0..5 in MSB-first numbering) must be clear.
  function automatic logic b0_legal(input logic [0:7] b0);
    return (b0[0:5] == 6'd0);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Program loader: parses MAGIC/LEN/words/CSUM frames from the host link,
// writes 18-bit instruction words from address 0 upward and releases the
// cpu only after a frame with a good checksum. Bit 0 is the MSB on all buses.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC     = DEFAULT_MAGIC,
  parameter int         MAX_WORDS = 65536,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [0:7]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  input  logic        i_restart,
  output logic        o_we,
  output logic [0:15] o_waddr,
  output logic [0:17] o_wdata,
  output logic        o_cpu_run,
  output logic        o_done,
  output logic        o_error
);

  localparam int             TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [16:0]    MAXW    = 17'(MAX_WORDS);

  state_e        state_q;
  logic [16:0]   len_q;
  logic [16:0]   cnt_q;
  logic [7:0]    csum_q;
  logic [1:0]    b0_q;
  logic [7:0]    b1_q;
  logic [TW-1:0] to_q;
  logic          rdy_q, we_q, run_q, done_q, err_q;
  logic [0:15]   waddr_q;
  logic [0:17]   wdata_q;

  logic          acc, in_frame, timeout_hit;
  logic [16:0]   len_w, cnt_nxt;
  logic [7:0]    csum_nxt;

  assign acc         = i_rx_valid & rdy_q;
  assign in_frame    = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  // Timeout fires on the clock where the idle count would reach TIMEOUT;
  // a byte accepted on that same clock wins.
  assign timeout_hit = in_frame && !acc && (to_q == TO_LAST);
  assign len_w       = {1'b0, len_q[15:8], i_rx_data};
  assign cnt_nxt     = cnt_q + 17'd1;
  assign csum_nxt    = csum_q ^ i_rx_data;

  // Frame FSM with registered outputs, word counter, checksum and timeout.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      to_q    <= '0;
      rdy_q   <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (in_frame && !acc) to_q <= to_q + TW'(1);
      else                  to_q <= '0;

      if (timeout_hit) begin
        state_q <= S_ERROR;
        err_q   <= 1'b1;
        rdy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (acc && i_rx_data == MAGIC) begin
            state_q <= S_LEN_HI;
            cnt_q   <= '0;
            csum_q  <= '0;
          end
          S_LEN_HI: if (acc) begin
            len_q[15:8] <= i_rx_data;
            csum_q      <= csum_nxt;
            state_q     <= S_LEN_LO;
          end
          S_LEN_LO: if (acc) begin
            len_q  <= len_w;
            csum_q <= csum_nxt;
            if (len_w == 17'd0) state_q <= S_CSUM;
            else if (len_w > MAXW) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              rdy_q   <= 1'b0;
            end else state_q <= S_B0;
          end
          S_B0: if (acc) begin
            csum_q <= csum_nxt;
            if (!b0_legal(i_rx_data)) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              rdy_q   <= 1'b0;
            end else begin
              b0_q    <= i_rx_data[6:7];
              state_q <= S_B1;
            end
          end
          S_B1: if (acc) begin
            b1_q    <= i_rx_data;
            csum_q  <= csum_nxt;
            state_q <= S_B2;
          end
          S_B2: if (acc) begin
            csum_q  <= csum_nxt;
            we_q    <= 1'b1;
            waddr_q <= cnt_q[15:0];
            wdata_q <= make_word(b0_q, b1_q, i_rx_data);
            cnt_q   <= cnt_nxt;
            state_q <= (cnt_nxt == len_q) ? S_CSUM : S_B0;
          end
          S_CSUM: if (acc) begin
            rdy_q <= 1'b0;
            if (i_rx_data == csum_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              run_q   <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end
          end
          S_DONE, S_ERROR: if (i_restart) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
            csum_q  <= '0;
          end
          default: begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
            rdy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_rx_ready = rdy_q;
  assign o_we       = we_q;
  assign o_waddr    = waddr_q;
  assign o_wdata    = wdata_q;
  assign o_cpu_run  = run_q;
  assign o_done     = done_q;
  assign o_error    = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frames are built from word lists, expected
// writes go into a scoreboard queue, a negedge monitor checks every o_we.
module tb_program_loader;

  localparam int TO   = 16;
  localparam int MAXW = 300;

  logic        i_clock = 1'b0;
  logic        i_reset_n = 1'b1;
  logic [0:7]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        i_restart = 1'b0;
  logic        o_rx_ready, o_we, o_cpu_run, o_done, o_error;
  logic [0:15] o_waddr;
  logic [0:17] o_wdata;

  program_loader #(.MAGIC(8'hA5), .MAX_WORDS(MAXW), .TIMEOUT(TO)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .i_restart(i_restart), .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_cpu_run(o_cpu_run), .o_done(o_done), .o_error(o_error)
  );

  always #5 i_clock = ~i_clock;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  typedef struct { longint addr; longint data; longint cyc; } exp_t;
  exp_t        exp_q[$];
  logic [17:0] words[$];

  initial forever begin
    @(posedge i_clock);
    cyc++;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write,
  // and must appear in the cycle right after its B2 handshake.
  initial forever begin
    @(negedge i_clock);
    if (o_we) begin
      if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("waddr", longint'(o_waddr), e.addr);
        chk("wdata", longint'(o_wdata), e.data);
        chk("we_latency", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    idle($urandom_range(0, maxgap));
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clock);
    #1;
    i_rx_valid = 1'b0;
  endtask

  // Reference: frame from the word list, checksum as plain XOR of LEN and payload bytes.
  task automatic send_frame(input bit bad_csum, input int maxgap);
    int         n;
    logic [7:0] cs, b0, b1, b2;
    n  = words.size();
    cs = 8'(n >> 8) ^ 8'(n);
    send(8'hA5, maxgap);
    send(8'(n >> 8), maxgap);
    send(8'(n), maxgap);
    for (int i = 0; i < n; i++) begin
      b0 = {6'd0, words[i][17:16]};
      b1 = words[i][15:8];
      b2 = words[i][7:0];
      cs = cs ^ b0 ^ b1 ^ b2;
      send(b0, maxgap);
      send(b1, maxgap);
      send(b2, maxgap);
      exp_q.push_back('{addr: longint'(i), data: longint'(words[i]), cyc: cyc});
    end
    send(bad_csum ? (cs ^ 8'h01) : cs, maxgap);
  endtask

  task automatic flags(input string nm, input bit done, input bit err, input bit run, input bit rdy);
    chk({nm, "_done"},  longint'(o_done),     longint'(done));
    chk({nm, "_error"}, longint'(o_error),    longint'(err));
    chk({nm, "_run"},   longint'(o_cpu_run),  longint'(run));
    chk({nm, "_ready"}, longint'(o_rx_ready), longint'(rdy));
  endtask

  task automatic restart(input string nm);
    i_restart = 1'b1;
    @(posedge i_clock);
    #1;
    i_restart = 1'b0;
    flags(nm, 0, 0, 0, 1);
  endtask

  task automatic reset_vals(input string nm);
    flags(nm, 0, 0, 0, 1);
    chk({nm, "_we"},    longint'(o_we),    0);
    chk({nm, "_waddr"}, longint'(o_waddr), 0);
    chk({nm, "_wdata"}, longint'(o_wdata), 0);
  endtask

  initial begin
    // Reset
    #2 i_reset_n = 1'b0;
    #1 reset_vals("reset");
    idle(3);
    i_reset_n = 1'b1;
    idle(1);

    // 1: two-word good frame
    words = '{18'h01234, 18'h3FFFF};
    send_frame(0, 2);
    flags("good", 1, 0, 1, 0);
    restart("restart1");

    // 2: same frame, bad checksum
    send_frame(1, 2);
    flags("badcsum", 0, 1, 0, 0);
    restart("restart2");

    // 3: garbage ignored, then empty frame
    send(8'h00, 1);
    send(8'hFF, 1);
    send(8'h5A, 1);
    words = {};
    send_frame(0, 1);
    flags("len0", 1, 0, 1, 0);
    restart("restart3");

    // 4: illegal B0
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h40, 0);
    flags("badb0", 0, 1, 0, 0);
    restart("restart4");

    // Length just above capacity
    send(8'hA5, 0);
    send(8'(MAXW >> 8), 0);
    send(8'(MAXW + 1), 0);
    flags("len_over", 0, 1, 0, 0);
    restart("restart5");

    // 5: timeout boundary, then async reset mid-frame
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    idle(TO - 1);
    chk("timeout_early", longint'(o_error), 0);
    idle(1);
    chk("timeout_hit", longint'(o_error), 1);
    chk("timeout_ready", longint'(o_rx_ready), 0);
    restart("restart6");
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h12, 0);
    #2 i_reset_n = 1'b0;
    #1 reset_vals("async_reset");
    @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    idle(1);

    // 6: 256 random words with random gaps
    words = {};
    for (int i = 0; i < 256; i++) words.push_back(18'($urandom));
    send_frame(0, 10);
    flags("big", 1, 0, 1, 0);
    idle(2);

    chk("scoreboard_empty", longint'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
